// File: rtl/ccc_csr_writeback_pkg.sv
// rtl/ccc_csr_writeback_pkg.sv - shared kinds and sizes for the CCC to CSR write-back path
package ccc_csr_writeback_pkg;

    typedef enum logic [2:0] {
        KIND_DYN      = 3'd0,
        KIND_VIRT_DYN = 3'd1,
        KIND_MWL      = 3'd2,
        KIND_MRL      = 3'd3,
        KIND_IBIL     = 3'd4
    } csr_wb_kind_e;

    localparam int CsrWbNumKinds = 5;

endpackage

// File: rtl/ccc_csr_writeback_prio_arb.sv
// rtl/ccc_csr_writeback_prio_arb.sv - fixed-priority picker, lowest kind index wins
module csr_wb_prio_arb
    import ccc_csr_writeback_pkg::*;
(
    input  logic [CsrWbNumKinds-1:0] pending_i,
    output csr_wb_kind_e             grant_o,
    output logic                     any_pending_o
);

    always_comb begin
        grant_o       = KIND_DYN;
        any_pending_o = |pending_i;
        // Scan high to low so the lowest set index is the last assignment.
        for (int i = CsrWbNumKinds - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                grant_o = csr_wb_kind_e'(i[2:0]);
            end
        end
    end

endmodule

// File: rtl/ccc_csr_writeback.sv
// rtl/ccc_csr_writeback.sv - captures CCC side effects and serialises them onto the CSR write channel
module ccc_csr_writeback
    import ccc_csr_writeback_pkg::*;
#(
    parameter logic [15:0] RstMwl  = 16'd256,
    parameter logic [15:0] RstMrl  = 16'd256,
    parameter logic [7:0]  RstIbil = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        set_dasa_i,
    input  logic        daa_done_i,
    input  logic        virt_i,
    input  logic [6:0]  dyn_addr_i,
    input  logic        rstdaa_i,
    input  logic        set_mwl_i,
    input  logic [15:0] mwl_i,
    input  logic        set_mrl_i,
    input  logic [15:0] mrl_i,
    input  logic        set_ibil_i,
    input  logic [7:0]  ibil_i,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic [2:0]  wr_kind_o,
    output logic [15:0] wr_data_o,
    output logic [15:0] get_mwl_o,
    output logic [15:0] get_mrl_o,
    output logic [7:0]  get_ibil_o,
    output logic        dyn_addr_chg_o
);

    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    state_e                              state_q, state_d;
    logic [CsrWbNumKinds-1:0]            pending_q, pending_d, arb_pending;
    logic [CsrWbNumKinds-1:0][15:0]      slot_q;
    logic [CsrWbNumKinds-1:0]            cap_vec;
    logic [CsrWbNumKinds-1:0][15:0]      cap_data;
    csr_wb_kind_e                        grant, wr_kind_q;
    logic                                any_pending, load, dyn_ev;
    logic [15:0]                         wr_data_q, load_data;
    logic [15:0]                         mwl_q, mrl_q;
    logic [7:0]                          ibil_q;
    logic                                chg_q;

    // RSTDAA overrides a coincident address assignment on both DYN kinds.
    always_comb begin
        dyn_ev      = set_dasa_i | daa_done_i;
        cap_vec     = '0;
        cap_data    = '0;
        cap_vec[0]  = rstdaa_i | (dyn_ev & ~virt_i);
        cap_data[0] = rstdaa_i ? 16'h0000 : {8'h00, 1'b1, dyn_addr_i};
        cap_vec[1]  = rstdaa_i | (dyn_ev & virt_i);
        cap_data[1] = rstdaa_i ? 16'h0000 : {8'h00, 1'b1, dyn_addr_i};
        cap_vec[2]  = set_mwl_i;
        cap_data[2] = mwl_i;
        cap_vec[3]  = set_mrl_i;
        cap_data[3] = mrl_i;
        cap_vec[4]  = set_ibil_i;
        cap_data[4] = {8'h00, ibil_i};
    end

    // A flush also keeps the arbiter from launching anything this edge.
    assign arb_pending = flush_i ? '0 : pending_q;

    csr_wb_prio_arb u_arb (
        .pending_i     (arb_pending),
        .grant_o       (grant),
        .any_pending_o (any_pending)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    load    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_ready_i) begin
                    if (any_pending) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pending_d = flush_i ? cap_vec : (pending_q | cap_vec);
        load_data = cap_vec[grant] ? cap_data[grant] : slot_q[grant];
        if (load) begin
            pending_d[grant] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            slot_q    <= '0;
            wr_kind_q <= KIND_DYN;
            wr_data_q <= 16'h0000;
            chg_q     <= 1'b0;
            mwl_q     <= RstMwl;
            mrl_q     <= RstMrl;
            ibil_q    <= RstIbil;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int k = 0; k < CsrWbNumKinds; k++) begin
                if (cap_vec[k]) begin
                    slot_q[k] <= cap_data[k];
                end
            end
            if (load) begin
                wr_kind_q <= grant;
                wr_data_q <= load_data;
            end
            chg_q <= (state_q == ST_REQ) && wr_ready_i &&
                     ((wr_kind_q == KIND_DYN) || (wr_kind_q == KIND_VIRT_DYN));
            if (set_mwl_i)  mwl_q  <= mwl_i;
            if (set_mrl_i)  mrl_q  <= mrl_i;
            if (set_ibil_i) ibil_q <= ibil_i;
        end
    end

    assign wr_valid_o     = (state_q == ST_REQ);
    assign wr_kind_o      = wr_kind_q;
    assign wr_data_o      = wr_data_q;
    assign get_mwl_o      = mwl_q;
    assign get_mrl_o      = mrl_q;
    assign get_ibil_o     = ibil_q;
    assign dyn_addr_chg_o = chg_q;

endmodule

// File: tb/tb_ccc_csr_writeback.sv
// tb/tb_ccc_csr_writeback.sv - directed self-checking bench for ccc_csr_writeback
module tb_ccc_csr_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, set_dasa, daa_done, virt, rstdaa;
    logic [6:0]  dyn_addr;
    logic        set_mwl, set_mrl, set_ibil;
    logic [15:0] mwl, mrl;
    logic [7:0]  ibil;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_kind;
    logic [15:0] wr_data, get_mwl, get_mrl;
    logic [7:0]  get_ibil;
    logic        chg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccc_csr_writeback dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .set_dasa_i(set_dasa), .daa_done_i(daa_done), .virt_i(virt),
        .dyn_addr_i(dyn_addr), .rstdaa_i(rstdaa),
        .set_mwl_i(set_mwl), .mwl_i(mwl), .set_mrl_i(set_mrl), .mrl_i(mrl),
        .set_ibil_i(set_ibil), .ibil_i(ibil),
        .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_kind_o(wr_kind),
        .wr_data_o(wr_data), .get_mwl_o(get_mwl), .get_mrl_o(get_mrl),
        .get_ibil_o(get_ibil), .dyn_addr_chg_o(chg)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events;
        flush = 0; set_dasa = 0; daa_done = 0; rstdaa = 0;
        set_mwl = 0; set_mrl = 0; set_ibil = 0;
    endtask

    task automatic check_wr(input string name, input logic ev, input logic [2:0] ek,
                            input logic [15:0] ed);
        checks++;
        if (wr_valid !== ev || (ev && (wr_kind !== ek || wr_data !== ed))) begin
            errors++;
            $display("FAIL %s: valid=%b kind=%0d data=%h, expected valid=%b kind=%0d data=%h",
                     name, wr_valid, wr_kind, wr_data, ev, ek, ed);
        end
    endtask

    task automatic test_reset;
        rst_n = 0; wr_ready = 0; virt = 0; dyn_addr = 0; mwl = 0; mrl = 0; ibil = 0;
        clear_events();
        repeat (3) tick();
        rst_n = 1;
        tick();
        checks++;
        if (get_mwl !== 16'd256 || get_mrl !== 16'd256 || get_ibil !== 8'd255) begin
            errors++;
            $display("FAIL reset_shadows: mwl=%0d mrl=%0d ibil=%0d, expected 256 256 255",
                     get_mwl, get_mrl, get_ibil);
        end
        checks++;
        if (wr_valid !== 1'b0 || wr_kind !== 3'd0 || wr_data !== 16'h0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b kind=%0d data=%h chg=%b, expected all 0",
                     wr_valid, wr_kind, wr_data, chg);
        end
    endtask

    task automatic test_setdasa;
        int pulses = 0;
        wr_ready = 1; set_dasa = 1; dyn_addr = 7'h3A; virt = 0;
        tick();
        clear_events();
        check_wr("dasa_not_yet", 1'b0, 3'd0, 16'h0);
        tick();
        check_wr("dasa_write", 1'b1, 3'd0, 16'h00BA);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (chg === 1'b1) pulses++;
            if (i == 0) check_wr("dasa_done", 1'b0, 3'd0, 16'h0);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL dasa_chg_pulses: got %0d, expected 1", pulses);
        end
    endtask

    task automatic test_back_to_back;
        wr_ready = 1;
        set_mwl = 1; mwl = 16'h0400; set_mrl = 1; mrl = 16'h0200; set_ibil = 1; ibil = 8'h10;
        tick();
        clear_events();
        checks++;
        if (get_mwl !== 16'h0400 || get_mrl !== 16'h0200 || get_ibil !== 8'h10) begin
            errors++;
            $display("FAIL b2b_shadows: mwl=%h mrl=%h ibil=%h, expected 0400 0200 10",
                     get_mwl, get_mrl, get_ibil);
        end
        tick();
        check_wr("b2b_mwl", 1'b1, 3'd2, 16'h0400);
        tick();
        check_wr("b2b_mrl", 1'b1, 3'd3, 16'h0200);
        tick();
        check_wr("b2b_ibil", 1'b1, 3'd4, 16'h0010);
        tick();
        check_wr("b2b_idle", 1'b0, 3'd0, 16'h0);
        checks++;
        if (chg !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_chg: chg=%b, expected 0", chg);
        end
    endtask

    task automatic test_hold_inflight;
        wr_ready = 0; set_mwl = 1; mwl = 16'h0100;
        tick();
        clear_events();
        tick();
        check_wr("hold_first", 1'b1, 3'd2, 16'h0100);
        set_mwl = 1; mwl = 16'h0080;
        tick();
        clear_events();
        check_wr("hold_stable0", 1'b1, 3'd2, 16'h0100);
        tick();
        check_wr("hold_stable1", 1'b1, 3'd2, 16'h0100);
        wr_ready = 1;
        tick();
        check_wr("hold_reissue", 1'b1, 3'd2, 16'h0080);
        tick();
        check_wr("hold_idle", 1'b0, 3'd0, 16'h0);
    endtask

    task automatic test_rstdaa;
        int pulses = 0;
        wr_ready = 1; rstdaa = 1; daa_done = 1; dyn_addr = 7'h11; virt = 1;
        tick();
        clear_events();
        tick();
        check_wr("rstdaa_dyn", 1'b1, 3'd0, 16'h0000);
        tick();
        check_wr("rstdaa_virt", 1'b1, 3'd1, 16'h0000);
        if (chg === 1'b1) pulses++;
        tick();
        check_wr("rstdaa_idle", 1'b0, 3'd0, 16'h0);
        if (chg === 1'b1) pulses++;
        tick();
        check_wr("rstdaa_idle2", 1'b0, 3'd0, 16'h0);
        if (chg === 1'b1) pulses++;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL rstdaa_chg_pulses: got %0d, expected 2", pulses);
        end
    endtask

    task automatic test_flush;
        wr_ready = 0;
        set_mwl = 1; mwl = 16'h0001; set_mrl = 1; mrl = 16'h0002; set_ibil = 1; ibil = 8'h03;
        tick();
        clear_events();
        tick();
        check_wr("flush_inflight", 1'b1, 3'd2, 16'h0001);
        flush = 1;
        tick();
        clear_events();
        check_wr("flush_held", 1'b1, 3'd2, 16'h0001);
        wr_ready = 1;
        tick();
        check_wr("flush_idle0", 1'b0, 3'd0, 16'h0);
        tick();
        check_wr("flush_idle1", 1'b0, 3'd0, 16'h0);
        tick();
        check_wr("flush_idle2", 1'b0, 3'd0, 16'h0);
    endtask

    task automatic test_async_reset;
        wr_ready = 0; set_mrl = 1; mrl = 16'h0055;
        tick();
        clear_events();
        tick();
        check_wr("arst_inflight", 1'b1, 3'd3, 16'h0055);
        #2 rst_n = 0;
        #1;
        checks++;
        if (wr_valid !== 1'b0 || wr_data !== 16'h0 || get_mrl !== 16'd256) begin
            errors++;
            $display("FAIL arst_abort: valid=%b data=%h mrl=%0d, expected 0 0000 256",
                     wr_valid, wr_data, get_mrl);
        end
        tick();
        rst_n = 1;
        wr_ready = 1;
        tick();
        tick();
        check_wr("arst_idle", 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_setdasa();
        test_back_to_back();
        test_hold_inflight();
        test_rstdaa();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
